inst_sequencer: RTL and testbench
=================================

// Module: inst_sequencer
// PURPOSE
//  Fetches 16-bit instruction words from a synchronous instruction ROM and feeds them to the proc
//  core one at a time: drives DIN, pulses Run, waits for Done, then advances PC.
//  Sits between the instruction memory and proc, and replaces the manual DIN/Run switches on the board.
//  Supports free-run and single-step modes, halt-word detection and a Done watchdog.
// PARAMETERS
//  AW         5        instruction address width (ROM depth 2**AW)
//  START_ADDR 0        PC value loaded on Start
//  TIMEOUT    8        maximum cycles in WAIT without Done before ERROR (>=4)
//  HALT_WORD  16'hE000 instruction word (III=111) that halts sequencing; it is never issued
// PORTS
//  Clock       in   1   clock; all state changes on posedge
//  Resetn      in   1   reset; synchronous, active-low
//  Start       in   1   level; begins execution from IDLE, HALTED or ERROR
//  StepMode    in   1   1 = pause after each instruction until Step
//  Step        in   1   single-cycle pulse; releases one instruction in PAUSE
//  MemAddr     out  AW  ROM address; registered, equals PC
//  MemData     in   16  ROM read data; valid 1 cycle after MemAddr changes
//  DIN         out  16  instruction word to proc; registered, stable from LOAD until next LOAD
//  Run         out  1   to proc; high for exactly one cycle per instruction (ISSUE)
//  Done        in   1   from proc; end of instruction
//  Busy        out  1   high in every state except IDLE, HALTED and ERROR
//  Halted      out  1   high in HALTED
//  Error       out  1   high in ERROR
//  InstrCount  out  16  count of completed instructions; wraps 16'hFFFF->0
// BEHAVIOUR
//  Reset: state=IDLE; PC=START_ADDR; MemAddr=START_ADDR; DIN=0; Run=0; InstrCount=0; watchdog=0;
//    all flags 0. Resetn is shared with proc, so a reset mid-instruction aborts both; no drain.
//  States: IDLE, FETCH, LOAD, ISSUE, WAIT, PAUSE, HALTED, ERROR.
//  IDLE/HALTED/ERROR + Start=1: PC=START_ADDR, InstrCount=0 -> FETCH. Start is ignored in other states.
//  FETCH: MemAddr=PC (already driven) -> LOAD (covers 1-cycle ROM latency).
//  LOAD: if MemData==HALT_WORD -> HALTED (PC holds the halt address); else DIN<=MemData -> ISSUE.
//  ISSUE: Run=1 for this cycle only; DIN is stable; watchdog<=0 -> WAIT.
//  WAIT: Done is sampled only here. Done=1: PC<=PC+1 (mod 2**AW, wraps to 0), InstrCount++;
//    then -> PAUSE if StepMode, else -> FETCH.
//    Done=0: watchdog++; when watchdog reaches TIMEOUT-1 with Done still 0 -> ERROR.
//  PAUSE: Step=1 -> FETCH; StepMode dropping to 0 in PAUSE also -> FETCH (resume free-run).
//  Done seen outside WAIT is ignored. Step outside PAUSE is ignored.
//  Latency: the first Run is asserted 3 cycles after Start is sampled (FETCH, LOAD, ISSUE).
//    Overhead is 3 cycles per instruction plus the proc execution time.
//    A 4-step add therefore occupies 7 cycles from FETCH to the next FETCH.
//  Flags Busy, Halted and Error are decoded from registered state; no combinational path from inputs.
// STRUCTURE
//  Shared package inst_seq_pkg: state enum (3-bit encoding), HALT_WORD default, opcode constants
//    mv/mvt/add/sub/halt (3'b000..3'b011, 3'b111).
//  Sub-module seq_watchdog (clear, enable, expired; width $clog2(TIMEOUT)), instantiated once.
//  Everything else lives in one always_ff next-state/register block and one decode block for outputs.
// TESTING
//  Bench uses proc as the DUT partner and a behavioural 1-cycle-latency ROM.
//  1 ROM = {mv r0,#5; add r0,#3; HALT}, Start pulse -> Run pulses=2, Halted=1, InstrCount=2, PC=2, r0=8.
//  2 StepMode=1, same ROM -> Busy=1 and Run stays low in PAUSE until Step.
//    Each Step gives exactly one Run; InstrCount is 1 after the first Step.
//  3 Proc model holds Done=0 -> Error=1 exactly TIMEOUT cycles after ISSUE, Run never re-asserted.
//    Start then -> PC=0, InstrCount=0, Error=0.
//  4 AW=2, ROM all mv r1,#1 (no HALT) -> PC sequence 0,1,2,3,0,1; InstrCount=6 after 6 Done.
//  5 Resetn=0 during WAIT of an add -> next cycle state=IDLE, Run=0, DIN=0, InstrCount=0.
//  6 Start held high while Busy -> no restart; PC and InstrCount are undisturbed.

Source files
------------

// File: rtl/inst_seq_pkg.sv
// Shared types and constants for the instruction sequencer that feeds the proc core.
// The state encoding is fixed at 3 bits. The opcode values match the proc instruction format.
package inst_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_ISSUE  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_PAUSE  = 3'd5,
    ST_HALTED = 3'd6,
    ST_ERROR  = 3'd7
  } seq_state_e;

  localparam logic [15:0] HALT_WORD_DEF = 16'hE000;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVT  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;

  // Only the three resting states count as not busy.
  function automatic logic is_busy_state(input seq_state_e s);
    case (s)
      ST_IDLE, ST_HALTED, ST_ERROR: return 1'b0;
      default:                      return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Counts WAIT cycles that pass without Done. It flags expiry on the cycle whose increment
// would bring the count to TIMEOUT-1, so that ERROR is entered TIMEOUT cycles after ISSUE.
module seq_watchdog #(
  parameter int TIMEOUT = 8
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST_C = CW'(TIMEOUT - 2);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  logic [CW-1:0] count_r;

  // cycle counter: clear has priority over enable
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable) begin
      count_r <= count_r + ONE_C;
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = enable && (count_r == LAST_C);

endmodule

// File: rtl/inst_sequencer.sv
// Fetches instruction words from a 1-cycle-latency ROM and issues them to proc one at a time.
// It supports free-run and single-step modes, halt-word detection and a Done watchdog.
module inst_sequencer
  import inst_seq_pkg::*;
#(
  parameter int              AW         = 5,
  parameter logic [AW-1:0]   START_ADDR = {AW{1'b0}},
  parameter int              TIMEOUT    = 8,
  parameter logic [15:0]     HALT_WORD  = HALT_WORD_DEF
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          Start,
  input  logic          StepMode,
  input  logic          Step,
  output logic [AW-1:0] MemAddr,
  input  logic [15:0]   MemData,
  output logic [15:0]   DIN,
  output logic          Run,
  input  logic          Done,
  output logic          Busy,
  output logic          Halted,
  output logic          Error,
  output logic [15:0]   InstrCount
);

  localparam logic [AW-1:0] PC_ONE  = AW'(1);
  localparam logic [15:0]   CNT_ONE = 16'h0001;

  seq_state_e    state_r;
  seq_state_e    next_state_s;
  logic [AW-1:0] pc_r;
  logic [15:0]   din_r;
  logic [15:0]   count_r;
  logic          run_r;
  logic          busy_r;
  logic          halted_r;
  logic          error_r;
  logic          wd_clear_s;
  logic          wd_enable_s;
  logic          wd_expired_s;

  assign wd_clear_s  = (state_r == ST_ISSUE);
  assign wd_enable_s = (state_r == ST_WAIT) && !Done;

  seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .clear   (wd_clear_s),
    .enable  (wd_enable_s),
    .expired (wd_expired_s)
  );

  // next-state decode
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE, ST_HALTED, ST_ERROR: begin
        if (Start) next_state_s = ST_FETCH;
        else       next_state_s = state_r;
      end
      ST_FETCH: next_state_s = ST_LOAD;
      ST_LOAD: begin
        if (MemData == HALT_WORD) next_state_s = ST_HALTED;
        else                      next_state_s = ST_ISSUE;
      end
      ST_ISSUE: next_state_s = ST_WAIT;
      ST_WAIT: begin
        if (Done)              next_state_s = StepMode ? ST_PAUSE : ST_FETCH;
        else if (wd_expired_s) next_state_s = ST_ERROR;
        else                   next_state_s = ST_WAIT;
      end
      ST_PAUSE: begin
        // Clearing StepMode while paused resumes free-run.
        if (Step || !StepMode) next_state_s = ST_FETCH;
        else                   next_state_s = ST_PAUSE;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // state, datapath and registered output flags
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_r  <= ST_IDLE;
      pc_r     <= START_ADDR;
      din_r    <= 16'h0000;
      count_r  <= 16'h0000;
      run_r    <= 1'b0;
      busy_r   <= 1'b0;
      halted_r <= 1'b0;
      error_r  <= 1'b0;
    end else begin
      state_r  <= next_state_s;
      run_r    <= (next_state_s == ST_ISSUE);
      busy_r   <= is_busy_state(next_state_s);
      halted_r <= (next_state_s == ST_HALTED);
      error_r  <= (next_state_s == ST_ERROR);
      case (state_r)
        ST_IDLE, ST_HALTED, ST_ERROR: begin
          if (Start) begin
            pc_r    <= START_ADDR;
            count_r <= 16'h0000;
          end
        end
        ST_LOAD: begin
          // The halt word is never presented to proc; PC stays on it.
          if (MemData != HALT_WORD) din_r <= MemData;
        end
        ST_WAIT: begin
          if (Done) begin
            pc_r    <= pc_r + PC_ONE;
            count_r <= count_r + CNT_ONE;
          end
        end
        default: begin
          pc_r <= pc_r;
        end
      endcase
    end
  end

  assign MemAddr    = pc_r;
  assign DIN        = din_r;
  assign Run        = run_r;
  assign Busy       = busy_r;
  assign Halted     = halted_r;
  assign Error      = error_r;
  assign InstrCount = count_r;

endmodule

// File: tb/tb_inst_sequencer.sv
// Scoreboard bench for inst_sequencer: ROM model, behavioural proc partner, queue-based issue checking.
`timescale 1ns/1ps
module tb_inst_sequencer;
  import inst_seq_pkg::*;

  localparam int          AW      = 3;
  localparam int          DEPTH   = 8;
  localparam int          TIMEOUT = 8;
  localparam logic [15:0] HALT    = 16'hE000;

  logic          Clock = 1'b0;
  logic          Resetn = 1'b0;
  logic          Start = 1'b0;
  logic          StepMode = 1'b0;
  logic          Step = 1'b0;
  logic          Done = 1'b0;
  logic [AW-1:0] MemAddr;
  logic [15:0]   MemData;
  logic [15:0]   DIN;
  logic          Run, Busy, Halted, Error;
  logic [15:0]   InstrCount;

  logic [15:0] rom [DEPTH];
  logic [15:0] regs [8];

  typedef struct { int addr; logic [15:0] word; } issue_t;
  issue_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int run_seen = 0;
  int proc_runs = 0;
  int hang_at = -1;

  always #5 Clock = ~Clock;

  inst_sequencer #(
    .AW(AW), .START_ADDR(3'd0), .TIMEOUT(TIMEOUT), .HALT_WORD(HALT)
  ) dut (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .StepMode(StepMode), .Step(Step),
    .MemAddr(MemAddr), .MemData(MemData), .DIN(DIN), .Run(Run), .Done(Done),
    .Busy(Busy), .Halted(Halted), .Error(Error), .InstrCount(InstrCount)
  );

  // synchronous ROM, one cycle of read latency
  always @(posedge Clock) MemData <= rom[MemAddr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] enc_imm(input logic [2:0] op, input logic [2:0] rx,
                                          input logic [8:0] imm);
    return {op, rx, 1'b1, imm};
  endfunction

  function automatic logic [15:0] rand_word();
    logic [2:0] op;
    op = 3'($urandom_range(0, 3));
    return {op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 9'($urandom_range(0, 511))};
  endfunction

  // reference: walk the ROM from the start address until the halt word or max_n issues
  task automatic expect_run(input int max_n, output int n, output int end_pc);
    int pc;
    pc = 0;
    n = 0;
    exp_q.delete();
    while (n < max_n && rom[pc] != HALT) begin
      issue_t e;
      e.addr = pc;
      e.word = rom[pc];
      exp_q.push_back(e);
      n++;
      pc = (pc + 1) % DEPTH;
    end
    end_pc = pc;
  endtask

  task automatic proc_exec(input logic [15:0] w);
    logic [15:0] opnd;
    opnd = w[9] ? {7'd0, w[8:0]} : regs[w[2:0]];
    case (w[15:13])
      OP_MV:   regs[w[12:10]] = opnd;
      OP_MVT:  regs[w[12:10]] = {w[7:0], 8'h00};
      OP_ADD:  regs[w[12:10]] = regs[w[12:10]] + opnd;
      OP_SUB:  regs[w[12:10]] = regs[w[12:10]] - opnd;
      default: ;
    endcase
  endtask

  // proc partner: executes on Run, answers Done 1..4 cycles into WAIT unless told to hang
  initial begin : proc_model
    int d;
    forever begin
      @(negedge Clock);
      if (Run && Resetn) begin
        proc_runs++;
        if (hang_at < 0 || proc_runs <= hang_at) begin
          proc_exec(DIN);
          d = $urandom_range(1, 4);
          repeat (d) @(negedge Clock);
          Done = 1'b1;
          @(negedge Clock);
          Done = 1'b0;
        end
      end
    end
  end

  // monitor: every Run pulse must match the next expected issue
  initial begin : monitor
    issue_t e;
    forever begin
      @(negedge Clock);
      if (Run) begin
        run_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_run: addr %0d din %h with no issue expected", MemAddr, DIN);
        end else begin
          e = exp_q.pop_front();
          check("issue_addr", 32'(MemAddr), 32'(e.addr));
          check("issue_din", 32'(DIN), 32'(e.word));
        end
      end
    end
  end

  function automatic bit cond_met(input int kind, input int val);
    case (kind)
      0:       return Halted;
      1:       return Error;
      2:       return InstrCount == 16'(val);
      3:       return Run;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_cond(input string name, input int kind, input int val, input int budget);
    int k;
    bit ok;
    k = 0;
    ok = cond_met(kind, val);
    while (!ok && k < budget) begin
      @(negedge Clock);
      k++;
      ok = cond_met(kind, val);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: condition not reached, waited %0d cycles, limit %0d", name, k, budget);
    end
  endtask

  task automatic do_reset();
    Resetn = 1'b0;
    Start = 1'b0;
    Step = 1'b0;
    StepMode = 1'b0;
    repeat (6) @(negedge Clock);
    exp_q.delete();
    run_seen = 0;
    proc_runs = 0;
    hang_at = -1;
    for (int i = 0; i < 8; i++) regs[i] = 16'h0000;
    Resetn = 1'b1;
    @(negedge Clock);
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
  endtask

  task automatic load_basic_rom();
    for (int i = 0; i < DEPTH; i++) rom[i] = rand_word();
    rom[0] = enc_imm(OP_MV, 3'd0, 9'd5);
    rom[1] = enc_imm(OP_ADD, 3'd0, 9'd3);
    rom[2] = HALT;
  endtask

  initial begin : global_limit
    #500000;
    errors++;
    $display("FAIL global_timeout: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : stimulus
    int n, end_pc, lat, hp, k, extra;
    for (int i = 0; i < DEPTH; i++) rom[i] = 16'h0000;

    // reset state
    do_reset();
    check("rst_memaddr", 32'(MemAddr), 32'd0);
    check("rst_din", 32'(DIN), 32'd0);
    check("rst_run", 32'(Run), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_halted", 32'(Halted), 32'd0);
    check("rst_error", 32'(Error), 32'd0);
    check("rst_count", 32'(InstrCount), 32'd0);

    // mv r0,#5; add r0,#3; HALT
    load_basic_rom();
    expect_run(100, n, end_pc);
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    lat = 1;
    while (!Run && lat < 10) begin
      @(negedge Clock);
      lat++;
    end
    check("start_to_run", 32'(lat), 32'd3);
    wait_cond("halt_basic", 0, 0, 100);
    check("basic_halted", 32'(Halted), 32'd1);
    check("basic_busy", 32'(Busy), 32'd0);
    check("basic_count", 32'(InstrCount), 32'(n));
    check("basic_pc", 32'(MemAddr), 32'(end_pc));
    check("basic_runs", 32'(run_seen), 32'd2);
    check("basic_r0", 32'(regs[0]), 32'd8);
    check("basic_queue", 32'(exp_q.size()), 32'd0);

    // random programs restarted from HALTED, halt at every kind of position
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < DEPTH; i++) rom[i] = rand_word();
      hp = (it == 0) ? 0 : $urandom_range(1, DEPTH - 1);
      rom[hp] = HALT;
      expect_run(100, n, end_pc);
      pulse_start();
      check("restart_halted_clear", 32'(Halted), 32'd0);
      wait_cond("halt_rand", 0, 0, 200);
      check("rand_count", 32'(InstrCount), 32'(n));
      check("rand_pc", 32'(MemAddr), 32'(end_pc));
      check("rand_queue", 32'(exp_q.size()), 32'd0);
    end

    // single-step mode
    do_reset();
    load_basic_rom();
    expect_run(100, n, end_pc);
    StepMode = 1'b1;
    pulse_start();
    wait_cond("step_first_done", 2, 1, 40);
    for (int c = 0; c < 5; c++) begin
      check("pause_busy", 32'(Busy), 32'd1);
      check("pause_run", 32'(Run), 32'd0);
      @(negedge Clock);
    end
    check("pause_runs", 32'(run_seen), 32'd1);
    Step = 1'b1;
    @(negedge Clock);
    Step = 1'b0;
    check("step1_count", 32'(InstrCount), 32'd1);
    wait_cond("step_second_done", 2, 2, 40);
    check("step2_runs", 32'(run_seen), 32'd2);
    Step = 1'b1;
    @(negedge Clock);
    Step = 1'b0;
    wait_cond("step_halt", 0, 0, 20);
    check("step_final_runs", 32'(run_seen), 32'd2);
    check("step_queue", 32'(exp_q.size()), 32'd0);
    StepMode = 1'b0;

    // Done watchdog: proc answers twice and then hangs
    do_reset();
    for (int i = 0; i < DEPTH; i++) rom[i] = rand_word();
    expect_run(3, n, end_pc);
    hang_at = 2;
    pulse_start();
    wait_cond("wd_two_done", 2, 2, 60);
    wait_cond("wd_third_run", 3, 0, 10);
    k = 0;
    extra = 0;
    while (!Error && k < 20) begin
      @(negedge Clock);
      k++;
      if (Run) extra++;
    end
    check("issue_to_error", 32'(k), 32'(TIMEOUT));
    check("wd_no_rerun", 32'(extra), 32'd0);
    check("wd_pc", 32'(MemAddr), 32'd2);
    check("wd_count", 32'(InstrCount), 32'd2);
    check("wd_busy", 32'(Busy), 32'd0);
    hang_at = -1;
    exp_q.delete();
    pulse_start();
    check("err_restart_error", 32'(Error), 32'd0);
    check("err_restart_pc", 32'(MemAddr), 32'd0);
    check("err_restart_count", 32'(InstrCount), 32'd0);
    check("err_restart_busy", 32'(Busy), 32'd1);

    // PC wrap with no halt word, with stray Step pulses outside PAUSE
    do_reset();
    for (int i = 0; i < DEPTH; i++) rom[i] = rand_word();
    expect_run(10, n, end_pc);
    pulse_start();
    k = 0;
    while (InstrCount != 16'd10 && k < 300) begin
      Step = 1'($urandom_range(0, 1));
      @(negedge Clock);
      k++;
    end
    Step = 1'b0;
    check("wrap_count", 32'(InstrCount), 32'd10);
    check("wrap_pc", 32'(MemAddr), 32'(end_pc));
    check("wrap_runs", 32'(run_seen), 32'd10);
    check("wrap_queue", 32'(exp_q.size()), 32'd0);

    // reset during WAIT
    do_reset();
    for (int i = 0; i < DEPTH; i++) rom[i] = rand_word();
    rom[2] = enc_imm(OP_ADD, 3'd1, 9'd7);
    expect_run(3, n, end_pc);
    pulse_start();
    wait_cond("rstw_two_done", 2, 2, 60);
    wait_cond("rstw_run", 3, 0, 10);
    @(negedge Clock);
    check("rstw_busy_before", 32'(Busy), 32'd1);
    Resetn = 1'b0;
    @(negedge Clock);
    check("rstw_run", 32'(Run), 32'd0);
    check("rstw_din", 32'(DIN), 32'd0);
    check("rstw_count", 32'(InstrCount), 32'd0);
    check("rstw_busy", 32'(Busy), 32'd0);
    check("rstw_pc", 32'(MemAddr), 32'd0);

    // Start held high while busy must not restart
    do_reset();
    for (int i = 0; i < DEPTH; i++) rom[i] = rand_word();
    rom[5] = HALT;
    expect_run(100, n, end_pc);
    Start = 1'b1;
    wait_cond("held_three", 2, 3, 100);
    check("held_pc", 32'(MemAddr), 32'd3);
    Start = 1'b0;
    wait_cond("held_halt", 0, 0, 100);
    check("held_count", 32'(InstrCount), 32'd5);
    check("held_final_pc", 32'(MemAddr), 32'd5);
    check("held_runs", 32'(run_seen), 32'd5);
    check("held_queue", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
